// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter in front of the single-port 64K x 16 data memory.
// Serves one access at a time (IDLE -> ACCESS -> ACK) and returns registered read data.
//
//  state  | meaning
//  IDLE   | waiting for a request; arbitrates and latches the winner's fields
//  ACCESS | memory port driven from latched fields; write/read commits at exit edge
//  ACK    | one-cycle ack pulse to the owner; memory port idle
module data_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_memw,
    output logic              mem_memr,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              last_grant;
    logic              owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              any_req;
    logic              grant_sel;

    assign any_req = m0_req | m1_req;

    // On a tie, round-robin hands the grant to whoever did not win last time.
    always_comb begin
        grant_sel = 1'b0;
        if (m0_req && m1_req) begin
            grant_sel = RR_EN ? ~last_grant : 1'b0;
        end else if (m1_req) begin
            grant_sel = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                last_grant <= grant_sel;
                owner      <= grant_sel;
                we_q       <= grant_sel ? m1_we    : m0_we;
                addr_q     <= grant_sel ? m1_addr  : m0_addr;
                wdata_q    <= grant_sel ? m1_wdata : m0_wdata;
            end
            if (state == ACCESS && !we_q) begin
                if (owner) begin
                    m1_rdata <= mem_read_data;
                end else begin
                    m0_rdata <= mem_read_data;
                end
            end
        end
    end

    // Write strobe is gated by rst so an abort never commits on the reset edge.
    always_comb begin
        mem_address    = addr_q;
        mem_write_data = wdata_q;
        mem_memw       = (state == ACCESS) & we_q & ~rst;
        mem_memr       = (state == ACCESS) & ~we_q;
        m0_ack         = (state == ACK) & ~owner;
        m1_ack         = (state == ACK) & owner;
        busy           = (state != IDLE);
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: one round-robin and one fixed-priority
// instance, each with its own behavioural 64K x 16 memory.
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        m0_ack, m1_ack, mem_memw, mem_memr, busy;
    logic [15:0] m0_rdata, m1_rdata, mem_address, mem_write_data, mem_read_data;

    logic        fp_m0_ack, fp_m1_ack, fp_memw, fp_memr, fp_busy;
    logic [15:0] fp_m0_rdata, fp_m1_rdata, fp_address, fp_write_data, fp_read_data;

    logic [15:0] mem_rr [0:65535];
    logic [15:0] mem_fp [0:65535];

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] pre_val;

    data_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RR_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_memw(mem_memw), .mem_memr(mem_memr), .mem_read_data(mem_read_data),
        .busy(busy)
    );

    data_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RR_EN(1'b0)) u_dut_fp (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(fp_m0_ack), .m0_rdata(fp_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(fp_m1_ack), .m1_rdata(fp_m1_rdata),
        .mem_address(fp_address), .mem_write_data(fp_write_data),
        .mem_memw(fp_memw), .mem_memr(fp_memr), .mem_read_data(fp_read_data),
        .busy(fp_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_memw) mem_rr[mem_address] <= mem_write_data;
        if (fp_memw)  mem_fp[fp_address]  <= fp_write_data;
    end

    assign mem_read_data = mem_memr ? mem_rr[mem_address] : 16'h0000;
    assign fp_read_data  = fp_memr  ? mem_fp[fp_address]  : 16'h0000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        m0_req = 1'b0;
        m1_req = 1'b0;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 16'h0; m0_wdata = 16'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 16'h0; m1_wdata = 16'h0;
        tick();
        reset_dut();

        check_val("rst_m0_ack", m0_ack, 1'b0);
        check_val("rst_m1_ack", m1_ack, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_memw", mem_memw, 1'b0);
        check_val("rst_memr", mem_memr, 1'b0);
        check_val("rst_m0_rdata", m0_rdata, 16'h0);
        check_val("rst_m1_rdata", m1_rdata, 16'h0);
        check_val("rst_addr", mem_address, 16'h0);

        // m0 write 0xBEEF -> 0x0010
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0010; m0_wdata = 16'hBEEF;
        tick();
        check_val("t1_memw_access", mem_memw, 1'b1);
        check_val("t1_addr", mem_address, 16'h0010);
        check_val("t1_wdata", mem_write_data, 16'hBEEF);
        check_val("t1_ack_early", m0_ack, 1'b0);
        tick();
        check_val("t1_m0_ack", m0_ack, 1'b1);
        check_val("t1_m1_ack", m1_ack, 1'b0);
        check_val("t1_memw_ack", mem_memw, 1'b0);
        check_val("t1_mem", mem_rr[16'h0010], 16'hBEEF);
        m0_req = 1'b0;
        tick();
        check_val("t1_ack_drop", m0_ack, 1'b0);
        check_val("t1_idle", busy, 1'b0);

        // m1 read 0x0010
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0010;
        tick();
        check_val("t2_memr", mem_memr, 1'b1);
        check_val("t2_memw", mem_memw, 1'b0);
        tick();
        check_val("t2_m1_ack", m1_ack, 1'b1);
        check_val("t2_m1_rdata", m1_rdata, 16'hBEEF);
        check_val("t2_m0_rdata", m0_rdata, 16'h0);
        m1_req = 1'b0;
        tick();

        // simultaneous requests after reset: m0 first, m1 three cycles later
        reset_dut();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0010;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0030; m1_wdata = 16'h5555;
        tick();
        check_val("t3_first_addr", mem_address, 16'h0010);
        tick();
        check_val("t3_m0_ack", m0_ack, 1'b1);
        check_val("t3_m1_ack_wait", m1_ack, 1'b0);
        check_val("t3_m0_rdata", m0_rdata, 16'hBEEF);
        m0_req = 1'b0;
        tick();
        tick();
        check_val("t3_second_memw", mem_memw, 1'b1);
        check_val("t3_second_addr", mem_address, 16'h0030);
        tick();
        check_val("t3_m1_ack", m1_ack, 1'b1);
        check_val("t3_m0_ack_off", m0_ack, 1'b0);
        check_val("t3_mem", mem_rr[16'h0030], 16'h5555);
        m1_req = 1'b0;
        tick();

        // both held: round-robin alternates, fixed priority always picks m0
        reset_dut();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0010;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0030;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("t4_busy_access", busy, 1'b1);
            check_val("t4_fp_m1_ack_a", fp_m1_ack, 1'b0);
            tick();
            check_val("t4_rr_m0_ack", m0_ack, (k % 2 == 0) ? 1'b1 : 1'b0);
            check_val("t4_rr_m1_ack", m1_ack, (k % 2 == 1) ? 1'b1 : 1'b0);
            check_val("t4_fp_m0_ack", fp_m0_ack, 1'b1);
            check_val("t4_fp_m1_ack_b", fp_m1_ack, 1'b0);
            if (k == 1) check_val("t4_rr_m1_rdata", m1_rdata, 16'h5555);
            check_val("t4_fp_m0_rdata", fp_m0_rdata, 16'hBEEF);
            tick();
            check_val("t4_fp_m1_ack_c", fp_m1_ack, 1'b0);
        end
        check_val("t4_rr_m0_rdata", m0_rdata, 16'hBEEF);
        m0_req = 1'b0;
        m1_req = 1'b0;

        // reset during ACCESS of a write aborts it
        reset_dut();
        pre_val = mem_rr[16'h0020];
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0020; m0_wdata = 16'hFFFF;
        tick();
        check_val("t5_memw_before", mem_memw, 1'b1);
        rst = 1'b1;
        #1;
        check_val("t5_memw_gated", mem_memw, 1'b0);
        tick();
        rst = 1'b0;
        m0_req = 1'b0;
        check_val("t5_mem_kept", mem_rr[16'h0020], pre_val);
        check_val("t5_no_ack", m0_ack, 1'b0);
        check_val("t5_idle", busy, 1'b0);
        tick();
        check_val("t5_no_ack_late", m0_ack, 1'b0);
        check_val("t5_still_idle", busy, 1'b0);

        // top address write then read
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'hFFFF; m0_wdata = 16'h1234;
        tick();
        check_val("t6_busy_access", busy, 1'b1);
        tick();
        check_val("t6_busy_ack", busy, 1'b1);
        check_val("t6_wr_ack", m0_ack, 1'b1);
        check_val("t6_rdata_unchanged", m0_rdata, 16'h0);
        m0_req = 1'b0;
        tick();
        check_val("t6_busy_idle", busy, 1'b0);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'hFFFF;
        tick();
        check_val("t6_rd_addr", mem_address, 16'hFFFF);
        tick();
        check_val("t6_rd_ack", m0_ack, 1'b1);
        check_val("t6_rdata", m0_rdata, 16'h1234);
        m0_req = 1'b0;
        tick();
        tick();
        check_val("t6_rdata_held", m0_rdata, 16'h1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
